// File: rtl/peripheral_sync_ctrl.sv
// -----------------------------------------------------------------------------
// peripheral_sync_ctrl
//
// Sequencer for the MMIO-commit synchronisation path between the DUT core and
// the reference side. Qualifying commits (isMMIO && valid && wenable) are
// queued in a DEPTH-entry FIFO and presented one at a time on syn_reg1 /
// syn_reg2 under a four-phase valid/ack handshake with the consumer.
//
// Parameters:
//   DEPTH          FIFO entries (power of two, 2..16)
//   TIMEOUT_CYCLES HOLD watchdog limit (only with PERIPHERAL_SYNC_TIMEOUT_EN)
//
// Optional feature macro: PERIPHERAL_SYNC_TIMEOUT_EN
//   defined   : HOLD watchdog drops an unacknowledged entry and sets timeout
//   undefined : HOLD waits indefinitely, timeout tied to 0
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   dutpc/instrcnt/rfData, valid, wenable, isMMIO   commit inputs
//   syn_ack             consumer acknowledge (four-phase)
//   syn_reg1            {instrcnt, dutpc} of the presented entry
//   syn_reg2            {64'b0, rfData} of the presented entry
//   syn_valid           syn_reg* hold an unconsumed entry
//   dut_stall           FIFO full, DUT must hold further MMIO commits
//   overflow            sticky, a commit was dropped
//   drop_cnt            saturating count of dropped commits
//   timeout             sticky watchdog flag
// -----------------------------------------------------------------------------
module peripheral_sync_ctrl #(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [63:0]  dutpc,
    input  logic [63:0]  instrcnt,
    input  logic [63:0]  rfData,
    input  logic         valid,
    input  logic         wenable,
    input  logic         isMMIO,
    input  logic         syn_ack,
    output logic [127:0] syn_reg1,
    output logic [127:0] syn_reg2,
    output logic         syn_valid,
    output logic         dut_stall,
    output logic         overflow,
    output logic [15:0]  drop_cnt,
    output logic         timeout
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    // Elaboration-time parameter sanity checks
    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("peripheral_sync_ctrl: DEPTH must be a power of two in 2..16");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("peripheral_sync_ctrl: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_HOLD    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_next_s;

    // Entry layout: [191:128] instrcnt, [127:64] dutpc, [63:0] rfData
    logic [191:0]    mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic [CW-1:0]   count_next_s;

    logic            push_s;
    logic            pop_s;
    logic            full_s;
    logic            push_ok_s;
    logic            drop_s;
    logic            timeout_hit_s;
    logic [191:0]    head_s;

    logic [127:0]    syn_reg1_r;
    logic [127:0]    syn_reg2_r;
    logic            syn_valid_r;
    logic            dut_stall_r;
    logic            overflow_r;
    logic [15:0]     drop_cnt_r;

    // Push qualification and accept/drop decision; a pop in the same cycle
    // frees the slot, so a push against a full FIFO is still taken.
    always_comb begin
        push_s    = isMMIO && valid && wenable;
        full_s    = (count_r == FULL_LVL);
        push_ok_s = push_s && (!full_s || pop_s);
        drop_s    = push_s && full_s && !pop_s;
        head_s    = mem_r[rd_ptr_r];
    end

    // Next occupancy from accepted pushes and LOAD pops
    always_comb begin
        count_next_s = count_r;
        case ({push_ok_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase
    end

    // Handshake FSM next-state logic; the head entry is popped in LOAD
    always_comb begin
        state_next_s = state_r;
        pop_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (count_r != {CW{1'b0}}) begin
                    state_next_s = ST_LOAD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                pop_s        = 1'b1;
                state_next_s = ST_HOLD;
            end
            ST_HOLD: begin
                if (syn_ack) begin
                    state_next_s = ST_RELEASE;
                end else if (timeout_hit_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_HOLD;
                end
            end
            ST_RELEASE: begin
                if (!syn_ack) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RELEASE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FIFO storage; contents need no reset since pointers/count are flushed
    always_ff @(posedge clk) begin
        if (!reset && push_ok_s) begin
            mem_r[wr_ptr_r] <= {instrcnt, dutpc, rfData};
        end
    end

    // FIFO pointers, occupancy and the full-derived stall flag
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r    <= {AW{1'b0}};
            rd_ptr_r    <= {AW{1'b0}};
            count_r     <= {CW{1'b0}};
            dut_stall_r <= 1'b0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r     <= count_next_s;
            dut_stall_r <= (count_next_s == FULL_LVL);
        end
    end

    // Dropped-commit bookkeeping: sticky flag and saturating counter
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_r <= 1'b0;
            drop_cnt_r <= 16'h0000;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
            if (drop_cnt_r != 16'hFFFF) begin
                drop_cnt_r <= drop_cnt_r + 16'h0001;
            end
        end
    end

    // Presentation registers: loaded only in LOAD, held between entries
    always_ff @(posedge clk) begin
        if (reset) begin
            syn_reg1_r  <= 128'd0;
            syn_reg2_r  <= 128'd0;
            syn_valid_r <= 1'b0;
        end else begin
            if (state_r == ST_LOAD) begin
                syn_reg1_r <= head_s[191:64];
                syn_reg2_r <= {64'd0, head_s[63:0]};
            end
            syn_valid_r <= (state_next_s == ST_HOLD);
        end
    end

`ifdef PERIPHERAL_SYNC_TIMEOUT_EN
    localparam logic [31:0] TO_LIMIT = 32'(TIMEOUT_CYCLES);

    logic [31:0] hold_cnt_r;
    logic        timeout_r;

    // Watchdog fires on the edge that completes the TIMEOUT_CYCLES-th HOLD cycle
    always_comb begin
        timeout_hit_s = (state_r == ST_HOLD) && !syn_ack &&
                        ((hold_cnt_r + 32'd1) >= TO_LIMIT);
    end

    // HOLD cycle counter (cleared while loading) and sticky timeout flag
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt_r <= 32'd0;
            timeout_r  <= 1'b0;
        end else begin
            if (state_r == ST_LOAD) begin
                hold_cnt_r <= 32'd0;
            end else if (state_r == ST_HOLD) begin
                hold_cnt_r <= hold_cnt_r + 32'd1;
            end
            if (timeout_hit_s) begin
                timeout_r <= 1'b1;
            end
        end
    end

    assign timeout = timeout_r;
`else
    assign timeout_hit_s = 1'b0;
    assign timeout       = 1'b0;
`endif

    assign syn_reg1  = syn_reg1_r;
    assign syn_reg2  = syn_reg2_r;
    assign syn_valid = syn_valid_r;
    assign dut_stall = dut_stall_r;
    assign overflow  = overflow_r;
    assign drop_cnt  = drop_cnt_r;

endmodule

// File: tb/tb_peripheral_sync_ctrl.sv
// -----------------------------------------------------------------------------
// tb_peripheral_sync_ctrl
//
// Directed self-checking bench for peripheral_sync_ctrl (DEPTH = 4,
// TIMEOUT_CYCLES = 16). Inputs change 1 ns after each rising edge and outputs
// are checked at that same point, so each step() is one clock edge.
// -----------------------------------------------------------------------------
module tb_peripheral_sync_ctrl;

    logic         clk = 1'b0;
    logic         reset;
    logic [63:0]  dutpc;
    logic [63:0]  instrcnt;
    logic [63:0]  rfData;
    logic         valid;
    logic         wenable;
    logic         isMMIO;
    logic         syn_ack;
    logic [127:0] syn_reg1;
    logic [127:0] syn_reg2;
    logic         syn_valid;
    logic         dut_stall;
    logic         overflow;
    logic [15:0]  drop_cnt;
    logic         timeout;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [63:0] b_pc  [8];
    logic [63:0] b_cnt [8];
    logic [63:0] b_dat [8];
    int          order [5];

    always #5 clk = ~clk;

    peripheral_sync_ctrl #(
        .DEPTH          (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .dutpc     (dutpc),
        .instrcnt  (instrcnt),
        .rfData    (rfData),
        .valid     (valid),
        .wenable   (wenable),
        .isMMIO    (isMMIO),
        .syn_ack   (syn_ack),
        .syn_reg1  (syn_reg1),
        .syn_reg2  (syn_reg2),
        .syn_valid (syn_valid),
        .dut_stall (dut_stall),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt),
        .timeout   (timeout)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_commit(input logic [63:0] pc, input logic [63:0] cnt, input logic [63:0] dat);
        dutpc    = pc;
        instrcnt = cnt;
        rfData   = dat;
        isMMIO   = 1'b1;
        valid    = 1'b1;
        wenable  = 1'b1;
    endtask

    task automatic drive_idle();
        isMMIO  = 1'b0;
        valid   = 1'b0;
        wenable = 1'b0;
    endtask

    task automatic check_entry(input string tag, input logic [63:0] pc,
                               input logic [63:0] cnt, input logic [63:0] dat);
        chk({tag, ".reg1"}, syn_reg1, {cnt, pc});
        chk({tag, ".reg2"}, syn_reg2, {64'd0, dat});
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".reg1"},     syn_reg1,  128'd0);
        chk({tag, ".reg2"},     syn_reg2,  128'd0);
        chk({tag, ".valid"},    {127'd0, syn_valid}, 128'd0);
        chk({tag, ".stall"},    {127'd0, dut_stall}, 128'd0);
        chk({tag, ".overflow"}, {127'd0, overflow},  128'd0);
        chk({tag, ".drop_cnt"}, {112'd0, drop_cnt},  128'd0);
        chk({tag, ".timeout"},  {127'd0, timeout},   128'd0);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            b_pc[i]  = 64'h0000_0000_4000_0000 + 64'(i * 16);
            b_cnt[i] = 64'd100 + 64'(i);
            b_dat[i] = 64'hC0DE_0000_0000_0000 | 64'(i);
        end
        // presentation order after the burst: commits 2..5, then the one
        // accepted during the full-FIFO LOAD
        order[0] = 1; order[1] = 2; order[2] = 3; order[3] = 4; order[4] = 6;

        reset   = 1'b1;
        syn_ack = 1'b0;
        dutpc   = 64'd0;
        instrcnt = 64'd0;
        rfData  = 64'd0;
        drive_idle();

        // ---- reset state ----
        step();
        step();
        check_all_zero("reset");
        reset = 1'b0;
        step();
        check_all_zero("post_reset");

        // ---- single commit: valid 2 cycles after the push edge ----
        drive_commit(64'h8000_0100, 64'd5, 64'hDEAD_BEEF);
        step();
        drive_idle();
        chk("single.lat_n", {127'd0, syn_valid}, 128'd0);
        step();
        chk("single.lat_n1", {127'd0, syn_valid}, 128'd0);
        step();
        chk("single.lat_n2", {127'd0, syn_valid}, 128'd1);
        check_entry("single", 64'h8000_0100, 64'd5, 64'hDEAD_BEEF);
        syn_ack = 1'b1;
        step();
        chk("single.ack_drop", {127'd0, syn_valid}, 128'd0);
        syn_ack = 1'b0;
        step();
        for (int i = 0; i < 6; i++) begin
            step();
            chk("single.quiet", {127'd0, syn_valid}, 128'd0);
        end
        check_entry("single.retain", 64'h8000_0100, 64'd5, 64'hDEAD_BEEF);

        // ---- non-qualifying commits ----
        drive_commit(64'h1111, 64'd7, 64'h2222);
        isMMIO = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("nonmmio.valid", {127'd0, syn_valid}, 128'd0);
            chk("nonmmio.stall", {127'd0, dut_stall}, 128'd0);
        end
        drive_idle();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("nonmmio.after", {127'd0, syn_valid}, 128'd0);
        end

        // ---- burst of 6 with consumer stalled ----
        for (int i = 0; i < 6; i++) begin
            drive_commit(b_pc[i], b_cnt[i], b_dat[i]);
            step();
            if (i == 2) begin
                chk("burst.first_valid", {127'd0, syn_valid}, 128'd1);
                check_entry("burst.first", b_pc[0], b_cnt[0], b_dat[0]);
            end
            if (i == 3) begin
                chk("burst.stall_lo", {127'd0, dut_stall}, 128'd0);
            end
            if (i == 4) begin
                chk("burst.stall_hi", {127'd0, dut_stall}, 128'd1);
                chk("burst.ovf_lo",   {127'd0, overflow},  128'd0);
            end
            if (i == 5) begin
                chk("burst.ovf_hi",   {127'd0, overflow},  128'd1);
                chk("burst.drop1",    {112'd0, drop_cnt},  128'd1);
                chk("burst.stall_kp", {127'd0, dut_stall}, 128'd1);
            end
        end
        drive_idle();

        // release entry 1, then push during the LOAD of entry 2 (FIFO full)
        syn_ack = 1'b1;
        step();
        chk("burst.ack1", {127'd0, syn_valid}, 128'd0);
        syn_ack = 1'b0;
        step();
        chk("full.stall_idle", {127'd0, dut_stall}, 128'd1);
        step();
        chk("full.in_load", {127'd0, syn_valid}, 128'd0);
        drive_commit(b_pc[6], b_cnt[6], b_dat[6]);
        step();
        drive_idle();
        chk("full.stall", {127'd0, dut_stall}, 128'd1);
        chk("full.drop",  {112'd0, drop_cnt},  128'd1);

        // drain in order with a zero-delay consumer (4-cycle entry period)
        for (int k = 0; k < 5; k++) begin
            chk("drain.valid", {127'd0, syn_valid}, 128'd1);
            check_entry("drain", b_pc[order[k]], b_cnt[order[k]], b_dat[order[k]]);
            chk("drain.stall", {127'd0, dut_stall}, (k == 0) ? 128'd1 : 128'd0);
            syn_ack = 1'b1;
            step();
            chk("drain.ack", {127'd0, syn_valid}, 128'd0);
            syn_ack = 1'b0;
            step();
            if (k < 4) begin
                step();
                chk("drain.gap", {127'd0, syn_valid}, 128'd0);
                step();
            end
        end
        for (int i = 0; i < 4; i++) begin
            step();
            chk("drain.empty", {127'd0, syn_valid}, 128'd0);
        end
        chk("drain.ovf_sticky", {127'd0, overflow},  128'd1);
        chk("drain.drop_keep",  {112'd0, drop_cnt},  128'd1);

        // ---- watchdog (or indefinite HOLD when the feature is off) ----
        drive_commit(b_pc[3], b_cnt[3], b_dat[3]);
        step();
        drive_commit(b_pc[5], b_cnt[5], b_dat[5]);
        step();
        drive_idle();
        step();
        chk("wd.present", {127'd0, syn_valid}, 128'd1);
        check_entry("wd.first", b_pc[3], b_cnt[3], b_dat[3]);
`ifdef PERIPHERAL_SYNC_TIMEOUT_EN
        for (int i = 0; i < 15; i++) begin
            step();
            chk("wd.hold", {127'd0, syn_valid}, 128'd1);
        end
        step();
        chk("wd.fall",    {127'd0, syn_valid}, 128'd0);
        chk("wd.timeout", {127'd0, timeout},   128'd1);
        check_entry("wd.stale", b_pc[3], b_cnt[3], b_dat[3]);
        step();
        chk("wd.gap", {127'd0, syn_valid}, 128'd0);
        step();
`else
        for (int i = 0; i < 30; i++) begin
            step();
        end
        chk("wd.still_hold", {127'd0, syn_valid}, 128'd1);
        chk("wd.no_timeout", {127'd0, timeout},   128'd0);
        syn_ack = 1'b1;
        step();
        syn_ack = 1'b0;
        step();
        step();
        step();
`endif
        chk("wd.next", {127'd0, syn_valid}, 128'd1);
        check_entry("wd.next", b_pc[5], b_cnt[5], b_dat[5]);
        syn_ack = 1'b1;
        step();
        syn_ack = 1'b0;
        step();

        // ---- reset mid-HOLD with 2 entries queued, commit during reset ----
        for (int i = 0; i < 3; i++) begin
            drive_commit(b_pc[i], b_cnt[i], b_dat[i]);
            step();
        end
        chk("rst.pre_valid", {127'd0, syn_valid}, 128'd1);
        drive_commit(b_pc[7], b_cnt[7], b_dat[7]);
        reset = 1'b1;
        step();
        reset = 1'b0;
        drive_idle();
        check_all_zero("rst.hold");
        for (int i = 0; i < 10; i++) begin
            step();
            chk("rst.quiet", {127'd0, syn_valid}, 128'd0);
        end
        chk("rst.stall", {127'd0, dut_stall}, 128'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/peripheral_sync_ctrl.md
# peripheral_sync_ctrl

Sequencer for the MMIO-commit synchronisation path between the DUT core and the reference side. Qualifying commits (`isMMIO && valid && wenable`) are buffered in a small FIFO and presented one at a time on two 128-bit sync registers under a four-phase valid/ack handshake. The block also raises back-pressure toward the DUT and records overflow. It replaces direct single-entry latching, so bursts of MMIO commits are no longer overwritten before the consumer reads them.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, 2..16.
- `TIMEOUT_CYCLES`, 1024: HOLD watchdog limit; used only with `PERIPHERAL_SYNC_TIMEOUT_EN`.

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `dutpc`  in  64  commit PC/tag word.
- `instrcnt`  in  64  commit instruction count.
- `rfData`  in  64  commit writeback data.
- `valid`  in  1  commit valid.
- `wenable`  in  1  register-write enable.
- `isMMIO`  in  1  commit is an MMIO access.
- `syn_ack`  in  1  consumer acknowledge (four-phase).
- `syn_reg1`  out  128  `{instrcnt, dutpc}` of the presented entry.
- `syn_reg2`  out  128  `{64'b0, rfData}` of the presented entry.
- `syn_valid`  out  1  the `syn_reg*` outputs hold an unconsumed entry.
- `dut_stall`  out  1  FIFO full; the DUT must hold further MMIO commits.
- `overflow`  out  1  sticky; set when a commit was dropped.
- `drop_cnt`  out  16  count of dropped commits; saturates at 16'hFFFF.
- `timeout`  out  1  sticky watchdog flag; constant 0 when the macro is off.

## Operation
- **Push.** A push occurs on a cycle where `isMMIO && valid && wenable`. The block writes the 192-bit entry `{instrcnt, dutpc, rfData}` at the tail.
- **Full FIFO.** If the FIFO is full and no pop happens in the same cycle, the push is dropped. `overflow` is set and `drop_cnt` increments, saturating.
- **Push and pop together.** A simultaneous push and pop is always accepted, even when full, and the count is unchanged.
- **Pointers.** Read and write pointers are `log2(DEPTH)` bits and wrap. The count register is `log2(DEPTH)+1` bits.
- `dut_stall` = (count == DEPTH), registered from the count.

FSM states and transitions:
- **IDLE.** If count != 0, go to LOAD.
- **LOAD.** Copy the head entry into `syn_reg1`/`syn_reg2`, pop it, go to HOLD.
- **HOLD.** `syn_valid` = 1. When `syn_ack` = 1, go to RELEASE.
- **RELEASE.** `syn_valid` = 0. When `syn_ack` = 0, go to IDLE.
- If `syn_ack` is already high on entry to HOLD, the block leaves HOLD on the next edge. HOLD still lasts at least 1 cycle.
- `syn_reg1`/`syn_reg2` change only in LOAD. Between entries they retain the last presented value.

Reset, applied on any cycle including mid-handshake:
- State returns to IDLE and the FIFO is flushed.
- `syn_reg1` = 0, `syn_reg2` = 0, `syn_valid` = 0, `dut_stall` = 0, `overflow` = 0, `drop_cnt` = 0, `timeout` = 0.
- A commit coincident with reset is discarded.

## Timing
- A push on edge N makes the entry visible in count after edge N.
- From an empty FIFO: IDLE→LOAD at edge N+1, and `syn_valid` = 1 after edge N+2. Commit-to-presentation latency is 2 cycles.
- `syn_ack` rising sampled at edge M drops `syn_valid` after edge M.
- `syn_ack` falling sampled at edge K gives IDLE after K.
- The next entry shows `syn_valid` after K+2. Minimum entry period is 4 cycles with a zero-delay consumer.
- `overflow`/`drop_cnt` update on the same edge as the dropped push.
- `dut_stall` asserts on the edge that makes count == DEPTH and deasserts on the edge that pops it below DEPTH.

## Configuration
- Macro: `PERIPHERAL_SYNC_TIMEOUT_EN`.
- **Defined:** a 32-bit counter clears on HOLD entry and increments each HOLD cycle. When it reaches `TIMEOUT_CYCLES` with `syn_ack` still 0:
  - the FSM goes to IDLE and `syn_valid` drops;
  - the entry is discarded and `timeout` is set (sticky until reset);
  - `syn_reg*` keep the stale value.
- **Undefined:** no counter is built, HOLD waits indefinitely, and `timeout` is tied to 0.

## Test plan
- **Reset mid-HOLD.** Stimulus: reset with 2 entries queued and `syn_valid` = 1. Required: next cycle all outputs are 0; with no further pushes, `syn_valid` stays 0 for 10 cycles.
- **Single commit.** Stimulus: one commit with `dutpc` = 0x8000_0100, `instrcnt` = 5, `rfData` = 0xDEAD_BEEF at edge N. Required:
  - `syn_valid` = 1 after N+2;
  - `syn_reg1` = {64'd5, 64'h8000_0100};
  - `syn_reg2` = {64'd0, 64'hDEAD_BEEF};
  - after ack high then low, `syn_valid` stays 0.
- **Non-qualifying commits.** Stimulus: `valid` = `wenable` = 1 but `isMMIO` = 0 for 8 cycles. Required: count stays 0 and `syn_valid` stays 0.
- **Burst and overflow (DEPTH = 4).** Stimulus: 6 back-to-back commits, consumer holds `syn_ack` = 0. Required:
  - entry 1 is presented and pops in LOAD, so commits 2–5 fill the FIFO;
  - `dut_stall` = 1;
  - commit 6 is dropped, giving `overflow` = 1 and `drop_cnt` = 1;
  - after acking, entries 1–5 appear in order.
- **Push-while-full with concurrent pop.** Stimulus: FIFO full, FSM in LOAD, commit arrives. Required: the commit is accepted, count stays 4, `drop_cnt` is unchanged.
- **Watchdog (macro on, `TIMEOUT_CYCLES` = 16).** Stimulus: present an entry and never ack. Required: `syn_valid` falls after 16 HOLD cycles, `timeout` = 1, and the next queued entry is presented 2 cycles later.
